bus_scheduler: RTL

BUS_SCHEDULER -- requirements
Module: bus_scheduler

---
 rtl/bus_scheduler_if.sv | 21 ++
 rtl/bus_scheduler.sv | 121 ++++++++++++
 2 files changed

// File: rtl/bus_scheduler_if.sv
// Shared memory bus: the scheduler drives it as master, the memory answers as slave.
interface bus_scheduler_if;
    logic [31:0] address_out;
    logic        read_out;
    logic        write_out;
    logic [3:0]  write_mask_out;
    logic [31:0] write_value_out;
    logic [31:0] read_value_in;
    logic        ready_in;
    logic        fault_in;

    modport master (
        output address_out, read_out, write_out, write_mask_out, write_value_out,
        input  read_value_in, ready_in, fault_in
    );

    modport slave (
        input  address_out, read_out, write_out, write_mask_out, write_value_out,
        output read_value_in, ready_in, fault_in
    );
endinterface

// File: rtl/bus_scheduler.sv
// Round-robin scheduler of NREQ requesters onto one memory bus (IDLE/BUSY FSM).
// Optional watchdog enabled by defining BUS_SCHEDULER_TIMEOUT_EN.
module bus_scheduler #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ*32-1:0]   req_address_in,
    input  logic [NREQ-1:0]      req_read_in,
    input  logic [NREQ-1:0]      req_write_in,
    input  logic [NREQ*4-1:0]    req_write_mask_in,
    input  logic [NREQ*32-1:0]   req_write_value_in,
    output logic [NREQ*32-1:0]   req_read_value_out,
    output logic [NREQ-1:0]      req_ready_out,
    output logic [NREQ-1:0]      req_fault_out,
    bus_scheduler_if.master      mem,
    output logic [NREQ-1:0]      grant_out
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_next;
    logic [IW-1:0] ptr, ptr_next;
    logic [IW-1:0] gidx, gidx_next;
    logic [IW-1:0] pick;
    logic          pick_valid;
    logic [NREQ-1:0] active;
    logic          expired;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_param_check
        $error("bus_scheduler: NREQ or TIMEOUT out of range");
    end

    assign active = req_read_in | req_write_in;

    // First requester found scanning cyclically from ptr
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_valid && active[(int'(ptr) + k) % NREQ]) begin
                pick_valid = 1'b1;
                pick       = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end

`ifdef BUS_SCHEDULER_TIMEOUT_EN
    logic [15:0] wd;

    assign expired = (state == BUSY) && !mem.ready_in && (wd == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wd <= '0;
        else if (state == IDLE)
            wd <= '0;
        else if (!mem.ready_in)
            wd <= wd + 16'd1;
    end
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= '0;
            gidx  <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            gidx  <= gidx_next;
        end
    end

    // A dropped request takes priority over completion so an abandoned access never reports
    always_comb begin
        state_next          = state;
        ptr_next            = ptr;
        gidx_next           = gidx;
        grant_out           = '0;
        req_ready_out       = '0;
        req_fault_out       = '0;
        req_read_value_out  = '0;
        mem.address_out     = '0;
        mem.read_out        = 1'b0;
        mem.write_out       = 1'b0;
        mem.write_mask_out  = '0;
        mem.write_value_out = '0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    gidx_next  = pick;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                grant_out[gidx]     = 1'b1;
                mem.address_out     = req_address_in[int'(gidx)*32 +: 32];
                mem.read_out        = req_read_in[gidx];
                mem.write_out       = req_write_in[gidx];
                mem.write_mask_out  = req_write_in[gidx] ? req_write_mask_in[int'(gidx)*4 +: 4] : 4'b0;
                mem.write_value_out = req_write_value_in[int'(gidx)*32 +: 32];
                if (!active[gidx]) begin
                    state_next = IDLE;
                end else if (mem.ready_in || expired) begin
                    req_ready_out[gidx] = 1'b1;
                    req_fault_out[gidx] = mem.ready_in ? mem.fault_in : 1'b1;
                    if (mem.ready_in)
                        req_read_value_out[int'(gidx)*32 +: 32] = mem.read_value_in;
                    state_next = IDLE;
                    ptr_next   = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule
